// File: rtl/dmem_pkg.sv
// Shared size codes, byte-count decode and big-endian lane map for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NBYTES = 4;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_TRI  = 2'd3;

    // Byte offset 0 lives in the most significant lane.
    localparam logic [3:0][4:0] LANE_MSB = {5'd7, 5'd15, 5'd23, 5'd31};

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_TRI:  n = 3'd3;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_gen.sv
// Turns (offset, size, right-justified data) into big-endian byte enables and lane-aligned data.
module dmem_lane_gen
    import dmem_pkg::*;
(
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] data,
    output logic [NBYTES-1:0] byte_en,
    output logic [DATA_W-1:0] aligned_data,
    output logic              misaligned
);

    logic [2:0] nbytes;
    logic [2:0] pos;
    int         src;

    always_comb begin
        byte_en      = '0;
        aligned_data = '0;
        misaligned   = 1'b0;
        nbytes       = size_to_nbytes(size);
        pos          = '0;
        src          = 0;
        if (size == SZ_WORD) begin
            // Full-word writes always land on the containing aligned word.
            byte_en      = 4'hF;
            aligned_data = data;
            misaligned   = (offset != 2'd0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (3'(k) < nbytes) begin
                    pos = 3'(offset) + 3'(k);
                    src = int'(nbytes) - 1 - k;
                    if (pos <= 3'd3) begin
                        byte_en[pos[1:0]] = 1'b1;
                        aligned_data[LANE_MSB[pos[1:0]] -: 8] = data[8*src +: 8];
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data memory behind the MEM stage: posted one-entry write buffer with byte-wise read forwarding.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10,
    parameter string       INIT_FILE   = ""
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       data_address_2DM,
    input  logic [31:0]       data_write_2DM,
    input  logic [1:0]        data_write_size_2DM,
    input  logic              MemRead_2DM,
    input  logic              MemWrite_2DM,
    output logic [31:0]       data_read_fDM,
    output logic              err_misaligned,
    output logic              err_range,
    output logic [31:0]       write_count
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]  req_idx;
    logic [1:0]        req_off;
    logic              req_upper;
    logic [NBYTES-1:0] lg_be;
    logic [DATA_W-1:0] lg_data;
    logic              lg_mis;

    logic              buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]  buf_idx_q,   buf_idx_d;
    logic [NBYTES-1:0] buf_be_q,    buf_be_d;
    logic [DATA_W-1:0] buf_data_q,  buf_data_d;
    logic [31:0]       write_count_q, write_count_d;
    logic              err_mis_q,   err_mis_d;
    logic              err_rng_q,   err_rng_d;

    assign req_idx   = data_address_2DM[IDX_W+1:2];
    assign req_off   = data_address_2DM[1:0];
    assign req_upper = |data_address_2DM[31:IDX_W+2];

    dmem_lane_gen u_lane_gen (
        .offset       (req_off),
        .size         (data_write_size_2DM),
        .data         (data_write_2DM),
        .byte_en      (lg_be),
        .aligned_data (lg_data),
        .misaligned   (lg_mis)
    );

    // Capture the current write request; anything else empties the buffer.
    always_comb begin
        buf_valid_d   = 1'b0;
        buf_idx_d     = buf_idx_q;
        buf_be_d      = buf_be_q;
        buf_data_d    = buf_data_q;
        write_count_d = write_count_q;
        err_mis_d     = err_mis_q;
        err_rng_d     = err_rng_q;
        if (MemWrite_2DM) begin
            buf_valid_d   = 1'b1;
            buf_idx_d     = req_idx;
            buf_be_d      = lg_be;
            buf_data_d    = lg_data;
            write_count_d = write_count_q + 32'd1;
            err_mis_d     = err_mis_q | lg_mis;
        end
        if ((MemRead_2DM || MemWrite_2DM) && req_upper) begin
            err_rng_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            buf_valid_q   <= 1'b0;
            buf_idx_q     <= '0;
            buf_be_q      <= '0;
            buf_data_q    <= '0;
            write_count_q <= '0;
            err_mis_q     <= 1'b0;
            err_rng_q     <= 1'b0;
        end else begin
            buf_valid_q   <= buf_valid_d;
            buf_idx_q     <= buf_idx_d;
            buf_be_q      <= buf_be_d;
            buf_data_q    <= buf_data_d;
            write_count_q <= write_count_d;
            err_mis_q     <= err_mis_d;
            err_rng_q     <= err_rng_d;
        end
    end

    // Array is never reset; a reset-cleared buffer simply stops committing.
    always_ff @(posedge CLK) begin
        if (buf_valid_q) begin
            for (int i = 0; i < 4; i++) begin
                if (buf_be_q[i]) begin
                    mem_q[buf_idx_q][LANE_MSB[i] -: 8] <= buf_data_q[LANE_MSB[i] -: 8];
                end
            end
        end
    end

    // Read the addressed word regardless of MemRead_2DM, overlaying pending buffer bytes.
    always_comb begin
        data_read_fDM = mem_q[req_idx];
        if (buf_valid_q && (buf_idx_q == req_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (buf_be_q[i]) begin
                    data_read_fDM[LANE_MSB[i] -: 8] = buf_data_q[LANE_MSB[i] -: 8];
                end
            end
        end
    end

    assign err_misaligned = err_mis_q;
    assign err_range      = err_rng_q;
    assign write_count    = write_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stimulus queues expectations, a negedge monitor pops and compares.
module tb_dmem_responder;

    localparam int K_RD  = 0;
    localparam int K_WC  = 1;
    localparam int K_MIS = 2;
    localparam int K_RNG = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wsize;
    logic        re;
    logic        we;
    logic [31:0] rdata;
    logic        err_mis;
    logic        err_rng;
    logic [31:0] wcount;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    logic [31:0] act;
    logic        chk_valid;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 CLK = ~CLK;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .IDX_W       (10),
        .INIT_FILE   ("")
    ) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .data_address_2DM    (addr),
        .data_write_2DM      (wdata),
        .data_write_size_2DM (wsize),
        .MemRead_2DM         (re),
        .MemWrite_2DM        (we),
        .data_read_fDM       (rdata),
        .err_misaligned      (err_mis),
        .err_range           (err_rng),
        .write_count         (wcount)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int k, input logic [31:0] e, input string nm);
        exp_t it;
        it.kind = k;
        it.exp  = e;
        it.name = nm;
        sb_q.push_back(it);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        addr      = a;
        wdata     = d;
        wsize     = sz;
        we        = 1'b1;
        re        = 1'b0;
        chk_valid = 1'b0;
        step();
        we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic rd, input logic [31:0] e, input string nm);
        addr = a;
        re   = rd;
        we   = 1'b0;
        push_exp(K_RD, e, nm);
        chk_valid = 1'b1;
        step();
        chk_valid = 1'b0;
        re        = 1'b0;
    endtask

    task automatic check_reg(input int k, input logic [31:0] e, input string nm);
        we = 1'b0;
        re = 1'b0;
        push_exp(k, e, nm);
        chk_valid = 1'b1;
        step();
        chk_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        we = 1'b0;
        re = 1'b0;
        repeat (n) step();
    endtask

    // Monitor: whenever a check is presented, pop the oldest expectation and compare.
    always @(negedge CLK) begin
        if (chk_valid) begin
            n_vec = n_vec + 1;
            if (sb_q.size() == 0) begin
                n_miss = n_miss + 1;
                $display("FAIL sb_underflow: check presented with no expectation queued");
            end else begin
                cur = sb_q.pop_front();
                case (cur.kind)
                    K_RD:    act = rdata;
                    K_WC:    act = wcount;
                    K_MIS:   act = {31'd0, err_mis};
                    default: act = {31'd0, err_rng};
                endcase
                if (act !== cur.exp) begin
                    n_miss = n_miss + 1;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", cur.name, act, cur.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        RESET     = 1'b0;
        addr      = '0;
        wdata     = '0;
        wsize     = '0;
        re        = 1'b0;
        we        = 1'b0;
        chk_valid = 1'b0;
        step();
        check_reg(K_WC,  32'd0, "reset_write_count");
        check_reg(K_MIS, 32'd0, "reset_err_misaligned");
        check_reg(K_RNG, 32'd0, "reset_err_range");
        RESET = 1'b1;
        idle(1);

        do_write(32'h100, 32'h1122_3344, 2'd0);
        do_read(32'h100, 1'b1, 32'h1122_3344, "word_buffer_hit");
        idle(1);
        do_read(32'h100, 1'b1, 32'h1122_3344, "word_from_array");
        check_reg(K_WC, 32'd1, "write_count_one");

        do_write(32'h101, 32'h0000_00AB, 2'd1);
        do_read(32'h100, 1'b1, 32'h11AB_3344, "byte_write_101");

        do_write(32'h101, 32'h00CC_DDEE, 2'd3);
        do_write(32'h100, 32'h0000_5566, 2'd2);
        do_read(32'h100, 1'b1, 32'h5566_DDEE, "tri_then_half");
        check_reg(K_MIS, 32'd0, "no_misalign_yet");
        idle(1);
        do_read(32'h100, 1'b0, 32'h5566_DDEE, "nop_read_shows_word");

        do_write(32'h103, 32'h0000_BEEF, 2'd2);
        do_read(32'h100, 1'b1, 32'h5566_DDBE, "half_crosses_word");
        check_reg(K_MIS, 32'd1, "misalign_set");
        idle(2);
        check_reg(K_MIS, 32'd1, "misalign_sticky");
        check_reg(K_WC, 32'd5, "write_count_five");

        do_write(32'h200, 32'hCAFE_F00D, 2'd0);
        idle(2);
        do_write(32'h200, 32'hDEAD_BEEF, 2'd0);
        RESET = 1'b0;
        check_reg(K_WC,  32'd0, "mid_reset_write_count");
        check_reg(K_MIS, 32'd0, "mid_reset_err_misaligned");
        check_reg(K_RNG, 32'd0, "mid_reset_err_range");
        RESET = 1'b1;
        idle(1);
        do_read(32'h200, 1'b1, 32'hCAFE_F00D, "pending_write_lost");

        do_write(32'h0001_0004, 32'h1234_5678, 2'd0);
        do_read(32'h004, 1'b1, 32'h1234_5678, "alias_buffer_hit");
        check_reg(K_RNG, 32'd1, "range_error_set");
        do_read(32'h004, 1'b1, 32'h1234_5678, "alias_from_array");

        do_write(32'h302, 32'hA1B2_C3D4, 2'd0);
        do_read(32'h300, 1'b1, 32'hA1B2_C3D4, "word_misaligned_aligns");
        check_reg(K_MIS, 32'd1, "word_misaligned_flag");
        check_reg(K_WC, 32'd2, "write_count_after_reset");

        idle(1);
        if (sb_q.size() != 0) begin
            n_vec  = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL sb_leftover: %0d expectations never checked, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
